// File: rtl/controle_ula_pkg.sv
// Shared constants and types for the ALU control decoder and the mult/div sequencer.
package controle_ula_pkg;

    localparam logic [2:0] ULA_NOP = 3'b000;
    localparam logic [2:0] ULA_ADD = 3'b001;
    localparam logic [2:0] ULA_SUB = 3'b010;
    localparam logic [2:0] ULA_AND = 3'b011;
    localparam logic [2:0] ULA_OR  = 3'b100;
    localparam logic [2:0] ULA_XOR = 3'b110;
    localparam logic [2:0] ULA_SLT = 3'b111;

    localparam logic [5:0] FN_MULT  = 6'h18;
    localparam logic [5:0] FN_MULTU = 6'h19;
    localparam logic [5:0] FN_DIV   = 6'h1A;
    localparam logic [5:0] FN_DIVU  = 6'h1B;
    localparam logic [5:0] FN_ADD   = 6'h20;
    localparam logic [5:0] FN_SUB   = 6'h22;
    localparam logic [5:0] FN_AND   = 6'h24;
    localparam logic [5:0] FN_OR    = 6'h25;
    localparam logic [5:0] FN_XOR   = 6'h26;
    localparam logic [5:0] FN_SLT   = 6'h2A;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;
    localparam logic [1:0] ALUOP_NOP   = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2,
        DZ   = 2'd3
    } md_state_t;

    function automatic logic is_md_funct(input logic [5:0] f);
        return (f == FN_MULT) || (f == FN_MULTU) || (f == FN_DIV) || (f == FN_DIVU);
    endfunction

endpackage

// File: rtl/md_core.sv
// Iterative unsigned shift-add multiplier / restoring divider on operand magnitudes.
// Shares one register triple: r_hi = accumulator/remainder, r_lo = multiplier/quotient, r_m = multiplicand/divisor.
module md_core #(
    parameter int DATA_W = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  load,
    input  logic                  step,
    input  logic                  is_div,
    input  logic [DATA_W-1:0]     a_mag,
    input  logic [DATA_W-1:0]     b_mag,
    output logic                  last,
    output logic [2*DATA_W-1:0]   res_next
);

    localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

    logic [CNT_W-1:0]  cnt;
    logic              kind_div;
    logic [DATA_W-1:0] r_hi;
    logic [DATA_W-1:0] r_lo;
    logic [DATA_W-1:0] r_m;

    logic [DATA_W:0]   mul_sum;
    logic [DATA_W:0]   div_shift;
    logic [DATA_W+1:0] div_diff;
    logic [DATA_W-1:0] hi_n;
    logic [DATA_W-1:0] lo_n;

    // Value after the current step; the top commits this on the final step so no extra cycle is needed.
    always_comb begin
        mul_sum   = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_m} : {(DATA_W+1){1'b0}});
        div_shift = {r_hi, r_lo[DATA_W-1]};
        div_diff  = {1'b0, div_shift} - {2'b00, r_m};
        if (kind_div) begin
            hi_n = div_diff[DATA_W+1] ? div_shift[DATA_W-1:0] : div_diff[DATA_W-1:0];
            lo_n = {r_lo[DATA_W-2:0], ~div_diff[DATA_W+1]};
        end else begin
            hi_n = mul_sum[DATA_W:1];
            lo_n = {mul_sum[0], r_lo[DATA_W-1:1]};
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt      <= '0;
            kind_div <= 1'b0;
            r_hi     <= '0;
            r_lo     <= '0;
            r_m      <= '0;
        end else if (load) begin
            cnt      <= CNT_W'(DATA_W - 1);
            kind_div <= is_div;
            r_hi     <= '0;
            r_lo     <= is_div ? a_mag : b_mag;
            r_m      <= is_div ? b_mag : a_mag;
        end else if (step) begin
            r_hi <= hi_n;
            r_lo <= lo_n;
            if (cnt != '0) begin
                cnt <= cnt - 1'b1;
            end
        end
    end

    assign last     = (cnt == '0);
    assign res_next = {hi_n, lo_n};

endmodule

// File: rtl/controle_ula_seq.sv
// ALU control decode plus mult/div sequencer owning HI/LO, with start/busy/done handshake.
//   state | meaning
//   IDLE  | waiting for a qualifying mult/div start
//   RUN   | one iteration per cycle, counter counts down to 0
//   DONE  | hi/lo just committed, md_done pulse, may accept next start
//   DZ    | divide by zero, md_done + div_zero, hi/lo untouched
module controle_ula_seq
    import controle_ula_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int SEL_W  = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [5:0]        funct,
    input  logic [1:0]        alu_op,
    input  logic              start,
    input  logic [DATA_W-1:0] op_a,
    input  logic [DATA_W-1:0] op_b,
    output logic [SEL_W-1:0]  alu_sel,
    output logic              md_busy,
    output logic              md_done,
    output logic              div_zero,
    output logic [DATA_W-1:0] hi,
    output logic [DATA_W-1:0] lo
);

    md_state_t state, state_n;

    logic [2:0] sel_dec;

    always_comb begin
        sel_dec = ULA_NOP;
        case (alu_op)
            ALUOP_ADD: sel_dec = ULA_ADD;
            ALUOP_SUB: sel_dec = ULA_SUB;
            ALUOP_FUNCT: begin
                case (funct)
                    FN_ADD:  sel_dec = ULA_ADD;
                    FN_SUB:  sel_dec = ULA_SUB;
                    FN_AND:  sel_dec = ULA_AND;
                    FN_OR:   sel_dec = ULA_OR;
                    FN_XOR:  sel_dec = ULA_XOR;
                    FN_SLT:  sel_dec = ULA_SLT;
                    default: sel_dec = ULA_NOP;
                endcase
            end
            default: sel_dec = ULA_NOP;
        endcase
    end

    assign alu_sel = SEL_W'(sel_dec);

    logic              req_div;
    logic              req_signed;
    logic              accept;
    logic              b_zero;
    logic              a_neg;
    logic              b_neg;
    logic [DATA_W-1:0] a_mag;
    logic [DATA_W-1:0] b_mag;

    assign req_div    = (funct == FN_DIV) || (funct == FN_DIVU);
    assign req_signed = (funct == FN_MULT) || (funct == FN_DIV);
    assign b_zero     = (op_b == '0);
    assign accept     = start && (alu_op == ALUOP_FUNCT) && is_md_funct(funct) && (state != RUN);
    assign a_neg      = req_signed & op_a[DATA_W-1];
    assign b_neg      = req_signed & op_b[DATA_W-1];
    assign a_mag      = a_neg ? -op_a : op_a;
    assign b_mag      = b_neg ? -op_b : op_b;

    logic                  core_last;
    logic [2*DATA_W-1:0]   core_res;

    md_core #(.DATA_W(DATA_W)) u_core (
        .clk      (clk),
        .reset    (reset),
        .load     (accept && !(req_div && b_zero)),
        .step     (state == RUN),
        .is_div   (req_div),
        .a_mag    (a_mag),
        .b_mag    (b_mag),
        .last     (core_last),
        .res_next (core_res)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n = state;
        case (state)
            RUN: begin
                if (core_last) begin
                    state_n = DONE;
                end
            end
            default: begin
                state_n = IDLE;
                if (accept) begin
                    state_n = (req_div && b_zero) ? DZ : RUN;
                end
            end
        endcase
    end

    always_comb begin
        md_busy = (state == RUN);
        md_done = (state == DONE) || (state == DZ);
    end

    // Sign of product/quotient is a^b; remainder takes the dividend's sign.
    logic                kind_div_q;
    logic                neg_q;
    logic                neg_r;
    logic [2*DATA_W-1:0] prod_fix;
    logic [DATA_W-1:0]   hi_fix;
    logic [DATA_W-1:0]   lo_fix;

    always_comb begin
        prod_fix = neg_q ? -core_res : core_res;
        if (kind_div_q) begin
            hi_fix = neg_r ? -core_res[2*DATA_W-1:DATA_W] : core_res[2*DATA_W-1:DATA_W];
            lo_fix = neg_q ? -core_res[DATA_W-1:0] : core_res[DATA_W-1:0];
        end else begin
            hi_fix = prod_fix[2*DATA_W-1:DATA_W];
            lo_fix = prod_fix[DATA_W-1:0];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hi         <= '0;
            lo         <= '0;
            div_zero   <= 1'b0;
            kind_div_q <= 1'b0;
            neg_q      <= 1'b0;
            neg_r      <= 1'b0;
        end else begin
            if (accept) begin
                div_zero   <= req_div && b_zero;
                kind_div_q <= req_div;
                neg_q      <= a_neg ^ b_neg;
                neg_r      <= req_div & a_neg;
            end
            if ((state == RUN) && core_last) begin
                hi <= hi_fix;
                lo <= lo_fix;
            end
        end
    end

endmodule

// File: tb/tb_controle_ula_seq.sv
// Self-checking bench for controle_ula_seq: decode table, mult/div table with scoreboard, corner sequences.
`timescale 1ns/1ps
module tb_controle_ula_seq;

    localparam int DATA_W = 32;
    localparam int SEL_W  = 3;

    logic              clk = 1'b0;
    logic              reset;
    logic [5:0]        funct;
    logic [1:0]        alu_op;
    logic              start;
    logic [DATA_W-1:0] op_a;
    logic [DATA_W-1:0] op_b;
    logic [SEL_W-1:0]  alu_sel;
    logic              md_busy;
    logic              md_done;
    logic              div_zero;
    logic [DATA_W-1:0] hi;
    logic [DATA_W-1:0] lo;

    always #5 clk = ~clk;

    controle_ula_seq #(.DATA_W(DATA_W), .SEL_W(SEL_W)) dut (
        .clk      (clk),
        .reset    (reset),
        .funct    (funct),
        .alu_op   (alu_op),
        .start    (start),
        .op_a     (op_a),
        .op_b     (op_b),
        .alu_sel  (alu_sel),
        .md_busy  (md_busy),
        .md_done  (md_done),
        .div_zero (div_zero),
        .hi       (hi),
        .lo       (lo)
    );

    typedef struct {
        logic [1:0] alu_op;
        logic [5:0] funct;
        logic [2:0] sel;
    } dec_vec_t;

    typedef struct {
        logic [5:0]  funct;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dz;
    } md_vec_t;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dz;
    } exp_t;

    exp_t        sbq[$];
    int          total = 0;
    int          bad   = 0;
    logic [31:0] cur_hi = '0;
    logic [31:0] cur_lo = '0;

    dec_vec_t dec_tab[10];
    md_vec_t  md_tab[10];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic void model(input logic [5:0] fn, input logic [31:0] a, input logic [31:0] b,
                                  input logic [31:0] phi, input logic [31:0] plo,
                                  output logic [31:0] ehi, output logic [31:0] elo, output logic edz);
        logic signed [63:0] sa;
        logic signed [63:0] sb;
        logic signed [63:0] sq;
        logic signed [63:0] sr;
        logic [63:0]        p;
        edz = 1'b0;
        ehi = phi;
        elo = plo;
        case (fn)
            6'h18: begin
                sa = $signed({{32{a[31]}}, a});
                sb = $signed({{32{b[31]}}, b});
                p  = sa * sb;
                ehi = p[63:32];
                elo = p[31:0];
            end
            6'h19: begin
                p  = {32'h0, a} * {32'h0, b};
                ehi = p[63:32];
                elo = p[31:0];
            end
            6'h1A: begin
                if (b == 32'h0) edz = 1'b1;
                else begin
                    sa = $signed({{32{a[31]}}, a});
                    sb = $signed({{32{b[31]}}, b});
                    sq = sa / sb;
                    sr = sa % sb;
                    elo = sq[31:0];
                    ehi = sr[31:0];
                end
            end
            default: begin
                if (b == 32'h0) edz = 1'b1;
                else begin
                    elo = a / b;
                    ehi = a % b;
                end
            end
        endcase
    endfunction

    // Issue one op; expected result goes to the scoreboard and is popped when md_done is seen.
    task automatic run_op(input string name, input logic [5:0] fn, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] ehi, input logic [31:0] elo, input logic edz,
                          input bit no_wait, input int glitch_at);
        exp_t e;
        exp_t g;
        int   k;
        int   busy_n;
        int   elat;
        bit   seen;
        elat = edz ? 1 : DATA_W + 1;
        if (!no_wait) @(negedge clk);
        alu_op = 2'b10;
        funct  = fn;
        op_a   = a;
        op_b   = b;
        start  = 1'b1;
        e.hi = ehi;
        e.lo = elo;
        e.dz = edz;
        sbq.push_back(e);
        @(posedge clk);
        #1;
        start = 1'b0;
        op_a  = ~a;
        op_b  = 32'h0;
        busy_n = 0;
        seen   = 1'b0;
        for (k = 1; k <= DATA_W + 8; k++) begin
            @(negedge clk);
            if (md_done) begin
                seen = 1'b1;
                break;
            end
            if (md_busy) busy_n++;
            if (k == glitch_at) begin
                start  = 1'b1;
                funct  = 6'h1A;
                op_a   = 32'h55;
                op_b   = 32'h3;
            end else begin
                start = 1'b0;
            end
        end
        start = 1'b0;
        if (!seen) begin
            total++;
            bad++;
            $display("FAIL %s timeout: md_done not seen, required at cycle %0d", name, elat);
            void'(sbq.pop_front());
        end else begin
            check({name, " latency"}, 64'(k), 64'(elat));
            check({name, " busy cycles"}, 64'(busy_n), 64'(elat - 1));
            check({name, " busy at done"}, 64'(md_busy), 64'(0));
            g = sbq.pop_front();
            check({name, " hi"}, 64'(hi), 64'(g.hi));
            check({name, " lo"}, 64'(lo), 64'(g.lo));
            check({name, " div_zero"}, 64'(div_zero), 64'(g.dz));
            cur_hi = g.hi;
            cur_lo = g.lo;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] ehi;
        logic [31:0] elo;
        logic        edz;
        logic [5:0]  fn;
        logic [31:0] ra;
        logic [31:0] rb;

        dec_tab[0] = '{2'b00, 6'h00, 3'b001};
        dec_tab[1] = '{2'b01, 6'h00, 3'b010};
        dec_tab[2] = '{2'b11, 6'h20, 3'b000};
        dec_tab[3] = '{2'b10, 6'h20, 3'b001};
        dec_tab[4] = '{2'b10, 6'h22, 3'b010};
        dec_tab[5] = '{2'b10, 6'h24, 3'b011};
        dec_tab[6] = '{2'b10, 6'h25, 3'b100};
        dec_tab[7] = '{2'b10, 6'h26, 3'b110};
        dec_tab[8] = '{2'b10, 6'h2A, 3'b111};
        dec_tab[9] = '{2'b10, 6'h3F, 3'b000};

        md_tab[0] = '{6'h18, 32'hFFFFFFFD, 32'h00000007, 32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0};
        md_tab[1] = '{6'h19, 32'hFFFFFFFF, 32'h00000002, 32'h00000001, 32'hFFFFFFFE, 1'b0};
        md_tab[2] = '{6'h1A, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0};
        md_tab[3] = '{6'h1B, 32'h00000007, 32'h00000000, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b1};
        md_tab[4] = '{6'h1A, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0};
        md_tab[5] = '{6'h1B, 32'h00000064, 32'h00000007, 32'h00000002, 32'h0000000E, 1'b0};
        md_tab[6] = '{6'h1A, 32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 1'b0};
        md_tab[7] = '{6'h18, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 1'b0};
        md_tab[8] = '{6'h1A, 32'h00000005, 32'h00000000, 32'h40000000, 32'h00000000, 1'b1};
        md_tab[9] = '{6'h19, 32'h00000000, 32'hFFFFFFFF, 32'h00000000, 32'h00000000, 1'b0};

        reset  = 1'b1;
        start  = 1'b0;
        alu_op = 2'b00;
        funct  = 6'h00;
        op_a   = '0;
        op_b   = '0;
        repeat (2) @(negedge clk);
        check("reset md_busy", 64'(md_busy), 64'(0));
        check("reset md_done", 64'(md_done), 64'(0));
        check("reset div_zero", 64'(div_zero), 64'(0));
        check("reset hi", 64'(hi), 64'(0));
        check("reset lo", 64'(lo), 64'(0));
        reset = 1'b0;

        for (int i = 0; i < 10; i++) begin
            alu_op = dec_tab[i].alu_op;
            funct  = dec_tab[i].funct;
            #1;
            check($sformatf("decode[%0d] alu_sel", i), 64'(alu_sel), 64'(dec_tab[i].sel));
        end

        for (int i = 0; i < 10; i++) begin
            run_op($sformatf("md[%0d]", i), md_tab[i].funct, md_tab[i].a, md_tab[i].b,
                   md_tab[i].hi, md_tab[i].lo, md_tab[i].dz, 1'b0, 0);
        end

        for (int i = 0; i < 6; i++) begin
            fn = 6'h18 + 6'($urandom_range(0, 3));
            ra = $urandom;
            rb = (i == 3) ? 32'h0 : $urandom;
            model(fn, ra, rb, cur_hi, cur_lo, ehi, elo, edz);
            run_op($sformatf("rand[%0d]", i), fn, ra, rb, ehi, elo, edz, 1'b0, 0);
        end

        model(6'h18, 32'd1234, 32'd5678, cur_hi, cur_lo, ehi, elo, edz);
        run_op("start during run", 6'h18, 32'd1234, 32'd5678, ehi, elo, edz, 1'b0, 10);

        run_op("b2b first", 6'h19, 32'd3, 32'd4, 32'h0, 32'd12, 1'b0, 1'b0, 0);
        run_op("b2b second", 6'h18, 32'd5, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFB, 1'b0, 1'b1, 0);

        @(negedge clk);
        alu_op = 2'b10;
        funct  = 6'h18;
        op_a   = 32'd9;
        op_b   = 32'd9;
        start  = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (15) @(negedge clk);
        check("busy before reset", 64'(md_busy), 64'(1));
        reset = 1'b1;
        #1;
        check("mid-run reset md_busy", 64'(md_busy), 64'(0));
        check("mid-run reset hi", 64'(hi), 64'(0));
        check("mid-run reset lo", 64'(lo), 64'(0));
        @(negedge clk);
        reset  = 1'b0;
        cur_hi = '0;
        cur_lo = '0;
        run_op("after reset 5x6", 6'h18, 32'd5, 32'd6, 32'h0, 32'd30, 1'b0, 1'b0, 0);

        check("scoreboard empty", 64'(sbq.size()), 64'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/controle_ula_seq.md
Name: controle_ula_seq

Overview:
Parametrised successor to the ALU control decoder of the multicycle MIPS datapath. It keeps the combinational ALUOp/funct → ALU-select decode and adds an iterative multiply/divide sequencer for mult/multu/div/divu. The sequencer owns the HI/LO registers and gives the main control FSM a start/busy/done handshake. It sits between the main control unit, the register-file read ports (A/B) and the ALU.

Parameters:
DATA_W, 32, operand and HI/LO width; the iteration count equals DATA_W.
SEL_W, 3, width of the ALU operation select.

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
funct  in  6  instruction funct field
alu_op  in  2  ALUOp from main control
start  in  1  main control requests a mult/div; sampled on the rising edge of clk
op_a  in  DATA_W  rs operand; multiplicand or dividend
op_b  in  DATA_W  rt operand; multiplier or divisor
alu_sel  out  SEL_W  ALU operation select; combinational
md_busy  out  1  sequencer iterating
md_done  out  1  one-cycle pulse when the result is committed
div_zero  out  1  last accepted divide had divisor 0
hi  out  DATA_W  HI register (mult: upper product; div: remainder)
lo  out  DATA_W  LO register (mult: lower product; div: quotient)

Behaviour:
- alu_sel decode, zero latency, pure function of the alu_op/funct inputs:
  - alu_op 00 → 001 (add); 01 → 010 (sub); 11 → 000.
  - alu_op 10 → decode funct: 0x20 → 001, 0x22 → 010, 0x24 → 011, 0x25 → 100 (or), 0x26 → 110, 0x2A → 111 (slt); any other funct → 000.
  - alu_sel ignores the sequencer state.
- Reset:
  - state=IDLE.
  - md_busy=0, md_done=0, div_zero=0, hi=0, lo=0.
  - Iteration counter and internal registers cleared.
  - Applies immediately, including mid-operation; the partial result is discarded.
- FSM states:
  - IDLE: on start && alu_op==10 && funct∈{0x18 mult, 0x19 multu, 0x1A div, 0x1B divu}, latch the operands and op kind, clear div_zero, then:
    - divide with op_b==0 → DZ;
    - otherwise → RUN with cnt=DATA_W-1.
    - start with any other alu_op/funct is ignored.
  - RUN: md_busy=1. One shift-add (mult) or restoring-subtract (div) step per cycle. cnt decrements each cycle; at cnt==0 → DONE.
  - DONE: md_done=1, md_busy=0. hi/lo are written on the edge entering DONE and are therefore valid throughout DONE. Next edge → IDLE; a qualifying start in DONE is accepted exactly as in IDLE (back-to-back).
  - DZ: md_done=1, div_zero=1. hi/lo are left unchanged. Next edge → IDLE, with the same start acceptance as DONE.
- Latency, with start sampled at edge T:
  - md_busy is high for DATA_W cycles after T;
  - md_done pulses in cycle T+DATA_W+1;
  - divide-by-zero: md_done in cycle T+1.
- start while in RUN is ignored. Operand changes after acceptance have no effect.
- Arithmetic:
  - Signed ops use magnitudes internally, then apply the sign fix at commit.
  - mult/multu produce a full 2·DATA_W product in {hi,lo}.
  - div quotient truncates toward zero. Remainder sign follows the dividend.
  - Signed overflow: min_int / −1 → lo=min_int, hi=0, with no flag.
  - divu/multu treat operands as unsigned.
- hi/lo hold their value until the next completed op or reset. div_zero holds until the next accepted start.

Decomposition:
- Package controle_ula_pkg holds:
  - ALU select constants: ULA_ADD=001, ULA_SUB=010, ULA_AND=011, ULA_OR=100, ULA_XOR=110, ULA_SLT=111, ULA_NOP=000;
  - funct constants (0x18–0x1B, 0x20–0x2A);
  - ALUOp constants;
  - state enum {IDLE, RUN, DONE, DZ}.
- One sub-module, md_core: iterative multiply/divide datapath with counter and registers, ports for load/step/kind and raw 2·DATA_W result. controle_ula_seq holds the decode, the FSM and the sign fix-up.

Test Plan:
- Decode sweep: alu_op 00/01/11 and alu_op 10 with funct 0x20, 0x22, 0x24, 0x25, 0x26, 0x2A, 0x3F → alu_sel 001, 010, 000, 001, 010, 011, 100, 110, 111, 000 in the same cycle.
- mult: op_a=−3 (0xFFFFFFFD), op_b=7 → md_busy for 32 cycles, md_done at T+33, hi=0xFFFFFFFF, lo=0xFFFFFFEB.
- multu: 0xFFFFFFFF×2 → hi=0x00000001, lo=0xFFFFFFFE.
- div: −7/2 → lo=0xFFFFFFFD (−3), hi=0xFFFFFFFF (−1). Then divu 7/0 → md_done at T+1, div_zero=1, hi/lo unchanged.
- Robustness: start pulsed at cycle 10 of RUN → ignored, result of the first op unchanged. Back-to-back start during DONE → second op accepted and busy the next cycle.
- Reset asserted mid-RUN (cycle 15) → md_busy=0, hi=lo=0 immediately. A following mult 5×6 → lo=30, hi=0.
